// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//
// Stage map used throughout the pipeline sources:
//   A = fetch, B = decode, C = execute, D = memory, E = writeback.
package pipe_ctrl_pkg;

    // Controller state: either letting the pipeline run or holding it for mul/div.
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Default cycle budget for a mul/div op before it is abandoned.
    localparam int MD_TIMEOUT_DEFAULT = 64;

    // Register-file address width.
    localparam int REG_AW = 5;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the controller.
// master = pipeline side (reports hazards, consumes stalls/flushes),
// slave  = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_AW-1:0]     Rs1BH;
    logic [REG_AW-1:0]     Rs2BH;
    logic [REG_AW-1:0]     RdCH;
    logic                  MemReadCH;
    logic                  PCSrcCH;
    logic                  MdReqCH;
    logic                  MdDoneH;

    logic                  StallAH;
    logic                  StallBH;
    logic                  StallCH;
    logic                  FlushBH;
    logic                  FlushCH;
    logic                  MdStartH;
    logic                  MdErrH;
    logic [DATA_WIDTH-1:0] StallCountH;

    modport master (
        output Rs1BH, Rs2BH, RdCH, MemReadCH, PCSrcCH, MdReqCH, MdDoneH,
        input  StallAH, StallBH, StallCH, FlushBH, FlushCH, MdStartH, MdErrH, StallCountH
    );

    modport slave (
        input  Rs1BH, Rs2BH, RdCH, MemReadCH, PCSrcCH, MdReqCH, MdDoneH,
        output StallAH, StallBH, StallCH, FlushBH, FlushCH, MdStartH, MdErrH, StallCountH
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and async active-low clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, sticking at all-ones instead of wrapping.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller: load-use interlock, taken-branch flush and
// mul/div sequencing with a timeout watchdog, plus a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam int              TMO_W    = $clog2(MD_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q;
    logic             abort;
    logic             load_use;

    logic stall_a, stall_b, stall_c, flush_b, flush_c, md_start;

    // Load in C writes a register the instruction in B wants to read.
    assign load_use = bus.MemReadCH && (bus.RdCH != '0) &&
                      ((bus.RdCH == bus.Rs1BH) || (bus.RdCH == bus.Rs2BH));

    // Next-state and control outputs; everything forced quiet while in reset.
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        abort    = 1'b0;
        stall_a  = 1'b0;
        stall_b  = 1'b0;
        stall_c  = 1'b0;
        flush_b  = 1'b0;
        flush_c  = 1'b0;
        md_start = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (bus.PCSrcCH) begin
                        // Younger instructions in B and C are wrong-path: drop them.
                        flush_b = 1'b1;
                        flush_c = 1'b1;
                    end else if (bus.MdReqCH) begin
                        md_start = 1'b1;
                        stall_a  = 1'b1;
                        stall_b  = 1'b1;
                        stall_c  = 1'b1;
                        tmo_d    = '0;
                        state_d  = MD_WAIT;
                    end else if (load_use) begin
                        // Hold A/B one cycle and send a bubble into C.
                        stall_a = 1'b1;
                        stall_b = 1'b1;
                        flush_c = 1'b1;
                    end
                end

                MD_WAIT: begin
                    if (bus.MdDoneH) begin
                        // Result valid: release the pipeline this same cycle.
                        state_d = RUN;
                    end else if (tmo_q == TMO_LAST) begin
                        // Unit never answered: drop the op and flag it.
                        flush_c = 1'b1;
                        abort   = 1'b1;
                        state_d = RUN;
                    end else begin
                        stall_a = 1'b1;
                        stall_b = 1'b1;
                        stall_c = 1'b1;
                        tmo_d   = tmo_q + 1'b1;
                    end
                end

                default: state_d = RUN;
            endcase
        end
    end

    // State, watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_q | abort;
        end
    end

    sat_counter #(
        .WIDTH (DATA_WIDTH)
    ) u_stall_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_a),
        .count (bus.StallCountH)
    );

    assign bus.StallAH  = stall_a;
    assign bus.StallBH  = stall_b;
    assign bus.StallCH  = stall_c;
    assign bus.FlushBH  = flush_b;
    assign bus.FlushCH  = flush_c;
    assign bus.MdStartH = md_start;
    assign bus.MdErrH   = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (4-bit stall counter, 8-cycle mul/div timeout).
module tb_pipe_ctrl;

    localparam int DW  = 4;
    localparam int TMO = 8;

    // Control vector layout: {StallA, StallB, StallC, FlushB, FlushC, MdStart}
    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110010;
    localparam logic [5:0] C_BRANCH = 6'b000110;
    localparam logic [5:0] C_START  = 6'b111001;
    localparam logic [5:0] C_HOLD   = 6'b111000;
    localparam logic [5:0] C_ABORT  = 6'b000010;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    pipe_ctrl #(
        .DATA_WIDTH (DW),
        .MD_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bus.StallAH, bus.StallBH, bus.StallCH, bus.FlushBH, bus.FlushCH, bus.MdStartH};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Rs1BH     = '0;
        bus.Rs2BH     = '0;
        bus.RdCH      = '0;
        bus.MemReadCH = 1'b0;
        bus.PCSrcCH   = 1'b0;
        bus.MdReqCH   = 1'b0;
        bus.MdDoneH   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", 32'(ctl()), 32'(C_IDLE));
        check("reset_cnt", 32'(bus.StallCountH), 0);
        check("reset_err", 32'(bus.MdErrH), 0);
        rst_n = 1'b1;

        // Load-use on Rs2.
        bus.MemReadCH = 1'b1; bus.RdCH = 5'd5; bus.Rs1BH = 5'd3; bus.Rs2BH = 5'd5;
        #1;
        check("lu_rs2_ctl", 32'(ctl()), 32'(C_LU));
        check("lu_cnt_before", 32'(bus.StallCountH), 0);
        tick();
        clear_inputs();
        #1;
        check("lu_cnt_after", 32'(bus.StallCountH), 1);
        check("lu_release", 32'(ctl()), 32'(C_IDLE));

        // RdCH = x0 never interlocks, even when sources are x0.
        bus.MemReadCH = 1'b1; bus.RdCH = 5'd0; bus.Rs1BH = 5'd0; bus.Rs2BH = 5'd0;
        #1;
        check("lu_x0_ctl", 32'(ctl()), 32'(C_IDLE));

        // Load-use on Rs1; non-load with matching Rd does not interlock.
        bus.RdCH = 5'd7; bus.Rs1BH = 5'd7; bus.Rs2BH = 5'd1;
        #1;
        check("lu_rs1_ctl", 32'(ctl()), 32'(C_LU));
        bus.MemReadCH = 1'b0;
        #1;
        check("no_load_ctl", 32'(ctl()), 32'(C_IDLE));
        bus.MemReadCH = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("lu_rs1_cnt", 32'(bus.StallCountH), 2);

        // Branch beats load-use and mul/div request.
        bus.PCSrcCH = 1'b1; bus.MdReqCH = 1'b1;
        bus.MemReadCH = 1'b1; bus.RdCH = 5'd9; bus.Rs1BH = 5'd9;
        #1;
        check("branch_ctl", 32'(ctl()), 32'(C_BRANCH));
        tick();
        clear_inputs();
        #1;
        check("branch_state_run", 32'(ctl()), 32'(C_IDLE));
        check("branch_cnt", 32'(bus.StallCountH), 2);

        // Mul/div with done 4 cycles after start.
        bus.MdReqCH = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            bus.MdDoneH = (i == 4);
            #1;
            check($sformatf("md_cyc%0d", i), 32'(ctl()),
                  32'((i == 0) ? C_START : (i == 4) ? C_IDLE : C_HOLD));
            tick();
        end
        clear_inputs();
        #1;
        check("md_back_run", 32'(ctl()), 32'(C_IDLE));
        check("md_cnt", 32'(bus.StallCountH), 6);
        check("md_no_err", 32'(bus.MdErrH), 0);

        // Timeout: no done, abort 8 cycles after start.
        bus.MdReqCH = 1'b1;
        for (int i = 0; i <= TMO; i++) begin
            #1;
            check($sformatf("tmo_cyc%0d", i), 32'(ctl()),
                  32'((i == 0) ? C_START : (i == TMO) ? C_ABORT : C_HOLD));
            if (i == TMO) check("tmo_err_pre", 32'(bus.MdErrH), 0);
            tick();
        end
        clear_inputs();
        #1;
        check("tmo_err_set", 32'(bus.MdErrH), 1);
        check("tmo_cnt", 32'(bus.StallCountH), 14);
        check("tmo_back_run", 32'(ctl()), 32'(C_IDLE));

        // Error is sticky across a later load-use; counter reaches 15.
        bus.MemReadCH = 1'b1; bus.RdCH = 5'd2; bus.Rs1BH = 5'd2;
        #1;
        check("sticky_lu_ctl", 32'(ctl()), 32'(C_LU));
        tick();
        clear_inputs();
        #1;
        check("sticky_err", 32'(bus.MdErrH), 1);
        check("sticky_cnt", 32'(bus.StallCountH), 15);

        // Reset on cycle 2 of MD_WAIT.
        bus.MdReqCH = 1'b1;
        tick();
        tick();
        #1;
        check("rstmid_hold", 32'(ctl()), 32'(C_HOLD));
        rst_n = 1'b0;
        #1;
        check("rstmid_ctl", 32'(ctl()), 32'(C_IDLE));
        check("rstmid_cnt", 32'(bus.StallCountH), 0);
        check("rstmid_err", 32'(bus.MdErrH), 0);
        rst_n = 1'b1;
        #1;
        check("rstmid_restart", 32'(ctl()), 32'(C_START));

        // Continue that op: done arrives on the timeout cycle, done wins.
        tick();
        for (int i = 1; i <= TMO; i++) begin
            bus.MdDoneH = (i == TMO);
            #1;
            check($sformatf("tie_cyc%0d", i), 32'(ctl()),
                  32'((i == TMO) ? C_IDLE : C_HOLD));
            tick();
        end
        clear_inputs();
        #1;
        check("tie_no_err", 32'(bus.MdErrH), 0);
        check("tie_cnt", 32'(bus.StallCountH), 8);

        // Saturation: 20 consecutive load-use stall cycles from zero.
        do_reset();
        check("sat_cnt_zero", 32'(bus.StallCountH), 0);
        bus.MemReadCH = 1'b1; bus.RdCH = 5'd4; bus.Rs2BH = 5'd4;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_cnt14", 32'(bus.StallCountH), 14);
        end
        clear_inputs();
        #1;
        check("sat_cnt20", 32'(bus.StallCountH), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
